// File: rtl/ascon_ctrl_pkg.sv
// Shared types and constants for the ASCON-128 encryption phase scheduler.
package ascon_ctrl_pkg;

  localparam int ROUNDS_A       = 12;
  localparam int ROUNDS_B       = 6;
  localparam int ROUND_OFFSET_B = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    AD_WAIT = 3'd2,
    AD      = 3'd3,
    PT_WAIT = 3'd4,
    PT      = 3'd5,
    FINAL   = 3'd6,
    TAG     = 3'd7
  } state_t;

endpackage

// File: rtl/cpt_round_ctrl.sv
// 4-bit permutation round counter with a last-round flag for p12 or p6 phases.
module cpt_round_ctrl #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       mode_b,
  output logic [3:0] cnt,
  output logic       last
);

  logic [3:0] cnt_reg;

  // Clear wins over increment so a phase's last round also re-arms the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= 4'd0;
    end else if (clr) begin
      cnt_reg <= 4'd0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 4'd1;
    end
  end

  assign cnt  = cnt_reg;
  assign last = mode_b ? (cnt_reg == 4'(ROUNDS_B - 1)) : (cnt_reg == 4'(ROUNDS_A - 1));

endmodule

// File: rtl/fsm_ascon_aead.sv
// ASCON-128 encryption phase scheduler: INIT p12, AD p6 per block, PT p6 per block, FINAL p12, TAG.
module fsm_ascon_aead #(
  parameter int ROUNDS_A    = ascon_ctrl_pkg::ROUNDS_A,
  parameter int ROUNDS_B    = ascon_ctrl_pkg::ROUNDS_B,
  parameter int BLOCK_CNT_W = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [BLOCK_CNT_W-1:0] nb_ad_i,
  input  logic [BLOCK_CNT_W-1:0] nb_pt_i,
  input  logic                   data_valid_i,
  output logic                   data_ready_o,
  output logic [3:0]             round_o,
  output logic                   input_mode_o,
  output logic                   en_reg_state_o,
  output logic                   xor_begin_data_o,
  output logic                   xor_begin_key_o,
  output logic                   xor_end_key_o,
  output logic                   xor_end_dsep_o,
  output logic                   en_cipher_o,
  output logic                   en_tag_o,
  output logic                   busy_o,
  output logic                   done_o
);

  import ascon_ctrl_pkg::*;

  localparam logic [BLOCK_CNT_W-1:0] BLK_ONE = BLOCK_CNT_W'(1);
  localparam logic [3:0]             OFS_B   = 4'(ROUND_OFFSET_B);

  state_t                 state_reg, state_next;
  logic [BLOCK_CNT_W-1:0] ad_cnt_reg, ad_cnt_next;
  logic [BLOCK_CNT_W-1:0] pt_cnt_reg, pt_cnt_next;
  logic                   rnd_clr, rnd_en, rnd_mode_b, rnd_last;
  logic [3:0]             rnd_cnt;

  cpt_round_ctrl #(
    .ROUNDS_A (ROUNDS_A),
    .ROUNDS_B (ROUNDS_B)
  ) u_round (
    .clk    (clock_i),
    .rst    (reset_i),
    .clr    (rnd_clr),
    .en     (rnd_en),
    .mode_b (rnd_mode_b),
    .cnt    (rnd_cnt),
    .last   (rnd_last)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg  <= IDLE;
      ad_cnt_reg <= '0;
      pt_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ad_cnt_reg <= ad_cnt_next;
      pt_cnt_reg <= pt_cnt_next;
    end
  end

  assign busy_o = (state_reg != IDLE);

  // The round counter advances on every cycle that loads the state register.
  always_comb begin
    state_next       = state_reg;
    ad_cnt_next      = ad_cnt_reg;
    pt_cnt_next      = pt_cnt_reg;
    rnd_clr          = 1'b0;
    rnd_en           = 1'b0;
    rnd_mode_b       = 1'b0;
    data_ready_o     = 1'b0;
    round_o          = 4'd0;
    input_mode_o     = 1'b0;
    en_reg_state_o   = 1'b0;
    xor_begin_data_o = 1'b0;
    xor_begin_key_o  = 1'b0;
    xor_end_key_o    = 1'b0;
    xor_end_dsep_o   = 1'b0;
    en_cipher_o      = 1'b0;
    en_tag_o         = 1'b0;
    done_o           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          ad_cnt_next = nb_ad_i;
          pt_cnt_next = (nb_pt_i == '0) ? BLK_ONE : nb_pt_i;
          rnd_clr     = 1'b1;
          state_next  = INIT;
        end
      end
      INIT: begin
        en_reg_state_o = 1'b1;
        rnd_en         = 1'b1;
        round_o        = rnd_cnt;
        input_mode_o   = (rnd_cnt == 4'd0);
        if (rnd_last) begin
          xor_end_key_o  = 1'b1;
          xor_end_dsep_o = (ad_cnt_reg == '0);
          rnd_clr        = 1'b1;
          state_next     = (ad_cnt_reg != '0) ? AD_WAIT : PT_WAIT;
        end
      end
      AD_WAIT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_reg_state_o   = 1'b1;
          xor_begin_data_o = 1'b1;
          rnd_en           = 1'b1;
          round_o          = rnd_cnt + OFS_B;
          state_next       = AD;
        end
      end
      AD: begin
        en_reg_state_o = 1'b1;
        rnd_en         = 1'b1;
        rnd_mode_b     = 1'b1;
        round_o        = rnd_cnt + OFS_B;
        if (rnd_last) begin
          rnd_clr     = 1'b1;
          ad_cnt_next = (ad_cnt_reg != '0) ? ad_cnt_reg - BLK_ONE : '0;
          if (ad_cnt_reg <= BLK_ONE) begin
            xor_end_dsep_o = 1'b1;
            state_next     = PT_WAIT;
          end else begin
            state_next = AD_WAIT;
          end
        end
      end
      PT_WAIT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          en_cipher_o      = 1'b1;
          xor_begin_data_o = 1'b1;
          en_reg_state_o   = 1'b1;
          rnd_en           = 1'b1;
          // The last plaintext block starts p12 finalisation directly at round 0.
          if (pt_cnt_reg <= BLK_ONE) begin
            xor_begin_key_o = 1'b1;
            round_o         = rnd_cnt;
            state_next      = FINAL;
          end else begin
            round_o    = rnd_cnt + OFS_B;
            state_next = PT;
          end
        end
      end
      PT: begin
        en_reg_state_o = 1'b1;
        rnd_en         = 1'b1;
        rnd_mode_b     = 1'b1;
        round_o        = rnd_cnt + OFS_B;
        if (rnd_last) begin
          rnd_clr     = 1'b1;
          pt_cnt_next = (pt_cnt_reg != '0) ? pt_cnt_reg - BLK_ONE : '0;
          state_next  = PT_WAIT;
        end
      end
      FINAL: begin
        en_reg_state_o = 1'b1;
        rnd_en         = 1'b1;
        round_o        = rnd_cnt;
        if (rnd_last) begin
          xor_end_key_o = 1'b1;
          rnd_clr       = 1'b1;
          state_next    = TAG;
        end
      end
      TAG: begin
        en_tag_o   = 1'b1;
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fsm_ascon_aead.sv
// Directed bench for the ASCON-128 phase scheduler: cycle timing, handshakes, XOR strobes, reset.
`timescale 1ns/1ps
module tb_fsm_ascon_aead;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic [3:0] nb_ad_i = 4'd0;
  logic [3:0] nb_pt_i = 4'd0;
  logic       data_valid_i = 1'b0;
  logic       data_ready_o;
  logic [3:0] round_o;
  logic       input_mode_o, en_reg_state_o, xor_begin_data_o, xor_begin_key_o;
  logic       xor_end_key_o, xor_end_dsep_o, en_cipher_o, en_tag_o, busy_o, done_o;
  logic [14:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  // Per-run observations
  int done_cycle, hs_cnt, cipher_cnt, dsep_cnt, dsep_cycle, endkey_cnt, endkey_first;
  int bkey_cnt, bkey_cycle, bkey_round, imode_cnt, imode_cycle, tag_cnt;
  int stall_cycles, stall_en_cnt, rnd_mism, rnd_len, rnd_exp_len;

  fsm_ascon_aead dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .start_i          (start_i),
    .nb_ad_i          (nb_ad_i),
    .nb_pt_i          (nb_pt_i),
    .data_valid_i     (data_valid_i),
    .data_ready_o     (data_ready_o),
    .round_o          (round_o),
    .input_mode_o     (input_mode_o),
    .en_reg_state_o   (en_reg_state_o),
    .xor_begin_data_o (xor_begin_data_o),
    .xor_begin_key_o  (xor_begin_key_o),
    .xor_end_key_o    (xor_end_key_o),
    .xor_end_dsep_o   (xor_end_dsep_o),
    .en_cipher_o      (en_cipher_o),
    .en_tag_o         (en_tag_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  assign outs = {data_ready_o, round_o, input_mode_o, en_reg_state_o, xor_begin_data_o,
                 xor_begin_key_o, xor_end_key_o, xor_end_dsep_o, en_cipher_o, en_tag_o,
                 busy_o, done_o};

  always #5 clock_i = ~clock_i;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one encryption; cycle 1 is the first cycle after the start edge.
  task automatic run_op(input logic [3:0] ad, input logic [3:0] pt, input logic [15:0] stall_mask,
                        input int stall_len, input bit start_in_final);
    logic [3:0] exp_rnd[$];
    int eff_pt, cyc, stall_left, post_busy;
    eff_pt = (pt == 4'd0) ? 1 : int'(pt);
    for (int i = 0; i < 12; i++) exp_rnd.push_back(4'(i));
    for (int b = 0; b < int'(ad) + eff_pt - 1; b++)
      for (int r = 6; r < 12; r++) exp_rnd.push_back(4'(r));
    for (int i = 0; i < 12; i++) exp_rnd.push_back(4'(i));
    rnd_exp_len = exp_rnd.size();
    done_cycle = -1; hs_cnt = 0; cipher_cnt = 0; dsep_cnt = 0; dsep_cycle = -1;
    endkey_cnt = 0; endkey_first = -1; bkey_cnt = 0; bkey_cycle = -1; bkey_round = -1;
    imode_cnt = 0; imode_cycle = -1; tag_cnt = 0; stall_cycles = 0; stall_en_cnt = 0;
    rnd_mism = 0; rnd_len = 0;
    stall_left = stall_len;
    @(negedge clock_i);
    nb_ad_i = ad; nb_pt_i = pt; start_i = 1'b1; data_valid_i = 1'b1;
    cyc = 0;
    while (done_cycle < 0 && cyc < 400) begin
      @(negedge clock_i);
      cyc++;
      start_i = start_in_final && (bkey_cnt > 0) && (cyc == bkey_cycle + 3);
      data_valid_i = 1'b1;
      #1;
      if (data_ready_o && hs_cnt < 16 && stall_mask[hs_cnt] && stall_left > 0) begin
        data_valid_i = 1'b0;
        stall_left--;
        #1;
        stall_cycles++;
        if (en_reg_state_o || xor_begin_data_o || en_cipher_o || xor_begin_key_o) stall_en_cnt++;
      end
      if (data_ready_o && data_valid_i) begin
        hs_cnt++;
        stall_left = stall_len;
      end
      if (en_reg_state_o) begin
        if (rnd_len < rnd_exp_len) begin
          if (round_o != exp_rnd[rnd_len]) rnd_mism++;
        end else begin
          rnd_mism++;
        end
        rnd_len++;
      end
      if (en_cipher_o) cipher_cnt++;
      if (xor_end_dsep_o) begin dsep_cnt++; dsep_cycle = cyc; end
      if (xor_end_key_o) begin endkey_cnt++; if (endkey_first < 0) endkey_first = cyc; end
      if (xor_begin_key_o) begin bkey_cnt++; bkey_cycle = cyc; bkey_round = int'(round_o); end
      if (input_mode_o) begin imode_cnt++; imode_cycle = cyc; end
      if (en_tag_o) tag_cnt++;
      if (done_o) done_cycle = cyc;
    end
    start_i = 1'b0;
    post_busy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_i);
      #1;
      if (busy_o || done_o) post_busy++;
    end
    check_val("idle_after_done", post_busy, 0);
    $display("run ad=%0d pt=%0d stall=%0d done_cycle=%0d handshakes=%0d ciphers=%0d",
             ad, pt, stall_len, done_cycle, hs_cnt, cipher_cnt);
  endtask

  initial begin
    int found, cyc, hs_local, late_done;
    repeat (2) @(negedge clock_i);
    #1;
    check_val("reset_outs", int'(outs), 0);
    reset_i = 1'b0;

    // nb_ad = 0, nb_pt = 1
    run_op(4'd0, 4'd1, 16'h0000, 0, 1'b0);
    check_val("a_done_cycle", done_cycle, 25);
    check_val("a_handshakes", hs_cnt, 1);
    check_val("a_endkey_first", endkey_first, 12);
    check_val("a_endkey_cnt", endkey_cnt, 2);
    check_val("a_dsep_cycle", dsep_cycle, 12);
    check_val("a_dsep_cnt", dsep_cnt, 1);
    check_val("a_bkey_cnt", bkey_cnt, 1);
    check_val("a_bkey_round", bkey_round, 0);
    check_val("a_bkey_cycle", bkey_cycle, 13);
    check_val("a_imode_cnt", imode_cnt, 1);
    check_val("a_imode_cycle", imode_cycle, 1);
    check_val("a_tag_cnt", tag_cnt, 1);
    check_val("a_round_mism", rnd_mism, 0);
    check_val("a_round_len", rnd_len, 24);

    // nb_ad = 2, nb_pt = 3
    run_op(4'd2, 4'd3, 16'h0000, 0, 1'b0);
    check_val("b_done_cycle", done_cycle, 49);
    check_val("b_handshakes", hs_cnt, 5);
    check_val("b_ciphers", cipher_cnt, 3);
    check_val("b_dsep_cnt", dsep_cnt, 1);
    check_val("b_dsep_cycle", dsep_cycle, 24);
    check_val("b_bkey_cycle", bkey_cycle, 37);
    check_val("b_round_mism", rnd_mism, 0);
    check_val("b_round_len", rnd_len, 48);

    // nb_ad = 1, nb_pt = 2 without and with a 4-cycle stall in AD_WAIT and PT_WAIT
    run_op(4'd1, 4'd2, 16'h0000, 0, 1'b0);
    check_val("s0_done_cycle", done_cycle, 37);
    run_op(4'd1, 4'd2, 16'h0003, 4, 1'b0);
    check_val("s1_done_cycle", done_cycle, 45);
    check_val("s1_stall_cycles", stall_cycles, 8);
    check_val("s1_enables_in_stall", stall_en_cnt, 0);
    check_val("s1_handshakes", hs_cnt, 3);
    check_val("s1_round_mism", rnd_mism, 0);

    // start pulsed during FINAL must be ignored
    run_op(4'd0, 4'd1, 16'h0000, 0, 1'b1);
    check_val("f_done_cycle", done_cycle, 25);
    check_val("f_tag_cnt", tag_cnt, 1);

    // nb_pt = 0 behaves as nb_pt = 1
    run_op(4'd1, 4'd0, 16'h0000, 0, 1'b0);
    check_val("p0_done_cycle", done_cycle, 31);
    check_val("p0_handshakes", hs_cnt, 2);
    check_val("p0_ciphers", cipher_cnt, 1);
    check_val("p0_round_mism", rnd_mism, 0);
    run_op(4'd1, 4'd1, 16'h0000, 0, 1'b0);
    check_val("p1_done_cycle", done_cycle, 31);

    // Reset in AD round 3 (round_o = 9 after the first AD handshake)
    @(negedge clock_i);
    nb_ad_i = 4'd2; nb_pt_i = 4'd1; start_i = 1'b1; data_valid_i = 1'b1;
    found = 0; hs_local = 0; cyc = 0;
    while (!found && cyc < 100) begin
      @(negedge clock_i);
      cyc++;
      start_i = 1'b0;
      #1;
      if (data_ready_o && data_valid_i) hs_local++;
      else if (hs_local >= 1 && en_reg_state_o && round_o == 4'd9) found = 1;
    end
    check_val("r_reached_ad_round3", found, 1);
    reset_i = 1'b1;
    #1;
    check_val("r_outs_during_reset", int'(outs), 0);
    @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
    #1;
    check_val("r_outs_after_reset", int'(outs), 0);
    late_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock_i);
      #1;
      if (done_o || busy_o) late_done++;
    end
    check_val("r_no_activity", late_done, 0);
    run_op(4'd2, 4'd1, 16'h0000, 0, 1'b0);
    check_val("r_fresh_done_cycle", done_cycle, 37);
    check_val("r_fresh_handshakes", hs_cnt, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fsm_ascon_aead.md
Name: fsm_ascon_aead

Overview:
- Top-level phase scheduler for the ASCON-128 encryption datapath: permutation round, state register, begin/end XOR stages, cipher and tag registers.
- Sequences four phases with a single round counter and a block counter: initialisation (p12), associated data (p6 per block), plaintext (p6 per block), finalisation (p12).
- Moves 64-bit data blocks in with a valid/ready handshake and signals tag availability.
- Supersedes the init-only sequencer; the datapath is unchanged.

Parameters:
- ROUNDS_A, 12, rounds for initialisation and finalisation.
- ROUNDS_B, 6, rounds per AD/plaintext block.
- BLOCK_CNT_W, 4, width of block-count inputs and internal block counter.

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  begin an encryption; sampled only in IDLE.
- nb_ad_i  in  BLOCK_CNT_W  number of AD blocks (0 allowed); latched on start.
- nb_pt_i  in  BLOCK_CNT_W  number of plaintext blocks; 0 is treated as 1; latched on start.
- data_valid_i  in  1  data block present on the datapath input.
- data_ready_o  out  1  FSM accepts a block; transfer occurs when valid and ready are both 1.
- round_o  out  4  round index for the constant-addition stage.
- input_mode_o  out  1  1 = permutation input takes IV||K||N; 0 = takes state register.
- en_reg_state_o  out  1  state register load enable.
- xor_begin_data_o  out  1  XOR data block into the rate at the permutation input.
- xor_begin_key_o  out  1  XOR key into the capacity at the permutation input.
- xor_end_key_o  out  1  XOR key into the low 128 bits at the permutation output.
- xor_end_dsep_o  out  1  XOR domain-separation bit at the permutation output.
- en_cipher_o  out  1  capture the ciphertext block.
- en_tag_o  out  1  capture the tag.
- busy_o  out  1  1 in every state except IDLE.
- done_o  out  1  one-cycle pulse when the tag is captured.

Behaviour:
- Reset (any time, including mid-operation): state = IDLE, counters = 0, all outputs 0. The operation is abandoned and no done_o is raised.
- Outputs are a function of state, counters and data_valid_i only. Ready/enable terms are gated by the handshake, so there is no registered output latency.
- State IDLE:
  - On start_i = 1, latch nb_ad_i and nb_pt_i (0 maps to 1), clear the round counter, go to INIT.
  - start_i in any other state is ignored.
- State INIT (ROUNDS_A cycles):
  - en_reg_state_o = 1; round_o = counter (0..11).
  - input_mode_o = 1 on round 0 only.
  - Last round: xor_end_key_o = 1; also xor_end_dsep_o = 1 if nb_ad = 0.
  - Exit to AD_WAIT if nb_ad > 0, otherwise PT_WAIT.
- State AD_WAIT:
  - data_ready_o = 1.
  - On handshake, perform round 0 in the same cycle: en_reg_state_o = 1, xor_begin_data_o = 1, round_o = 6. Then go to AD.
  - Without valid: hold, all enables 0.
- State AD (rounds 1..5 of p6):
  - round_o = counter + 6.
  - Last round: decrement the AD block count. If it reaches 0, xor_end_dsep_o = 1 and go to PT_WAIT; otherwise go to AD_WAIT.
- State PT_WAIT, remaining plaintext blocks > 1:
  - data_ready_o = 1.
  - Handshake: en_cipher_o = 1, xor_begin_data_o = 1, en_reg_state_o = 1, round_o = 6. Then go to PT.
- State PT_WAIT, remaining plaintext blocks = 1 (last block):
  - Handshake: en_cipher_o = 1, xor_begin_data_o = 1, xor_begin_key_o = 1, en_reg_state_o = 1, round_o = 0. Then go to FINAL.
- State PT (rounds 7..11): decrement the plaintext count on the last round, then go to PT_WAIT.
- State FINAL (rounds 1..11): en_reg_state_o = 1; last round xor_end_key_o = 1; then go to TAG.
- State TAG: en_tag_o = 1 and done_o = 1 for one cycle, en_reg_state_o = 0, then go to IDLE.
- Latency with valid held at 1: done_o rises 25 + 6*(nb_ad + nb_pt - 1) cycles after the start edge.
- Width rules:
  - The round counter is 4-bit and wraps only via an explicit clear at each phase entry.
  - Block counters saturate at 0 and never underflow.
- A valid deassert between blocks stalls in *_WAIT indefinitely. valid is ignored during round states.

Decomposition:
- Package ascon_ctrl_pkg holds:
  - state_t enum: IDLE, INIT, AD_WAIT, AD, PT_WAIT, PT, FINAL, TAG.
  - Constants ROUNDS_A, ROUNDS_B, ROUND_OFFSET_B = 6.
- Sub-module cpt_round_ctrl: 4-bit round counter with clear, enable and a last-round flag for 12- or 6-round mode. The FSM instantiates it once.

Test Plan:
- Reset mid-AD (nb_ad = 2, pulse reset_i in AD round 3): all outputs 0 next cycle; a fresh start completes normally.
- nb_ad = 0, nb_pt = 1, valid always 1:
  - xor_end_key_o and xor_end_dsep_o both high in INIT cycle 12.
  - xor_begin_key_o high with round_o = 0.
  - done_o at cycle 25.
- nb_ad = 2, nb_pt = 3, valid always 1:
  - exactly 5 handshakes; round_o sequence 6..11 per block.
  - xor_end_dsep_o only on the second AD block's last round.
  - en_cipher_o three times; done_o at cycle 49.
- Valid stalls (nb_ad = 1, nb_pt = 2, valid low for 4 cycles in each WAIT): en_reg_state_o = 0 while stalled; done_o delayed by exactly 8 cycles.
- start_i pulsed during FINAL: ignored, no restart. nb_pt_i = 0 behaves identically to nb_pt_i = 1.
